// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit frame controller: FSM state
// encoding, parity/line constants and a counter-width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

  // Bits needed to index n items (at least 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Request-side bus of the UART transmitter: parallel byte, frame options,
// bit period and the busy status returned to the front end.
interface uart_tx_frame_ctrl_if #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
);
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      Data_Valid;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    input  busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    output busy
  );
endinterface

// File: rtl/tx_baud_counter.sv
// Bit timing for the UART transmitter: an edge counter that wraps every
// Prescale cycles (0 treated as 1) producing bit_done, and a data-bit counter
// that advances on bit_done while count_bits is high.
module tx_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6,
  parameter int unsigned BitCntW        = cnt_width(DATA_WIDTH)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      Enable,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      count_bits,
  output logic                      bit_done,
  output logic [BitCntW-1:0]        bit_count
);

  logic [PRESCALE_WIDTH-1:0] edge_cnt_q;
  logic [PRESCALE_WIDTH-1:0] edge_last;
  logic [BitCntW-1:0]        bit_cnt_q;

  // Last count of a bit period; Prescale of 0 behaves as 1.
  always_comb begin
    edge_last = (Prescale == '0) ? '0 : Prescale - PRESCALE_WIDTH'(1);
    bit_done  = Enable && (edge_cnt_q == edge_last);
  end

  // Edge counter: held at zero while idle, wraps on each bit boundary.
  always_ff @(posedge CLK) begin
    if (!RST || !Enable) begin
      edge_cnt_q <= '0;
    end else if (bit_done) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_q + PRESCALE_WIDTH'(1);
    end
  end

  // Data-bit index: cleared whenever the FSM is outside the data phase.
  always_ff @(posedge CLK) begin
    if (!RST || !count_bits) begin
      bit_cnt_q <= '0;
    end else if (bit_done) begin
      bit_cnt_q <= bit_cnt_q + BitCntW'(1);
    end
  end

  assign bit_count = bit_cnt_q;

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmitter: serialises one latched byte per request into a
// start / data (LSB first) / optional parity / stop frame on TX_OUT.
// TX_OUT is registered so it only moves on bit boundaries.
// Optional feature macro: UART_TX_BREAK_EN adds a Break input that holds the
// line low (busy high) while asserted in idle.
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
`ifdef UART_TX_BREAK_EN
  input  logic                 Break,
`endif
  uart_tx_frame_ctrl_if.slave  req,
  output logic                 TX_OUT
);

  localparam int unsigned BitCntW = cnt_width(DATA_WIDTH);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_WIDTH - 1);

  tx_state_e                 state_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic [PRESCALE_WIDTH-1:0] ps_q;
  logic                      tx_q;
  logic                      busy_q;
`ifdef UART_TX_BREAK_EN
  logic                      brk_q;
`endif

  logic               bit_done;
  logic [BitCntW-1:0] bit_count;
  logic [BitCntW-1:0] next_idx;
  logic               parity;

  tx_baud_counter #(
    .DATA_WIDTH     (DATA_WIDTH),
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .BitCntW        (BitCntW)
  ) u_baud (
    .CLK        (CLK),
    .RST        (RST),
    .Enable     (state_q != StIdle),
    .Prescale   (ps_q),
    .count_bits (state_q == StData),
    .bit_done   (bit_done),
    .bit_count  (bit_count)
  );

  // Next data bit to present and the parity bit of the latched byte.
  always_comb begin
    next_idx = bit_count + BitCntW'(1);
    parity   = (par_typ_q == PAR_ODD) ? ~(^data_q) : ^data_q;
  end

  // Frame FSM with registered line level and busy; TX_OUT is loaded with the
  // value of the bit that starts at each boundary.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= StIdle;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      ps_q      <= '0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
`ifdef UART_TX_BREAK_EN
          if (brk_q) begin
            if (!Break) begin
              brk_q  <= 1'b0;
              tx_q   <= LINE_IDLE;
              busy_q <= 1'b0;
            end
          end else if (Break) begin
            brk_q  <= 1'b1;
            tx_q   <= 1'b0;
            busy_q <= 1'b1;
          end else
`endif
          if (req.Data_Valid) begin
            data_q    <= req.P_DATA;
            par_en_q  <= req.PAR_EN;
            par_typ_q <= req.PAR_TYP;
            ps_q      <= req.Prescale;
            state_q   <= StStart;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StStart: begin
          if (bit_done) begin
            state_q <= StData;
            tx_q    <= data_q[0];
          end
        end
        StData: begin
          if (bit_done) begin
            if (bit_count == LastBit) begin
              if (par_en_q) begin
                state_q <= StParity;
                tx_q    <= parity;
              end else begin
                state_q <= StStop;
                tx_q    <= LINE_IDLE;
              end
            end else begin
              tx_q <= data_q[next_idx];
            end
          end
        end
        StParity: begin
          if (bit_done) begin
            state_q <= StStop;
            tx_q    <= LINE_IDLE;
          end
        end
        StStop: begin
          if (bit_done) begin
            state_q <= StIdle;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= LINE_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT   = tx_q;
  assign req.busy = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: table of frames checked cycle by cycle
// against a queue of expected line/busy samples, plus back-to-back,
// mid-frame reset and (when enabled) break sequences.
module tb_uart_tx_frame_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic TX_OUT;
`ifdef UART_TX_BREAK_EN
  logic Break = 1'b0;
`endif

  uart_tx_frame_ctrl_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

  uart_tx_frame_ctrl #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (6)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
`ifdef UART_TX_BREAK_EN
    .Break  (Break),
`endif
    .req    (bus),
    .TX_OUT (TX_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic tx;
    logic busy;
  } samp_t;

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic [5:0]  ps;
    int unsigned exp_len;
    logic        exp_par;
  } vec_t;

  samp_t       exp_q[$];
  vec_t        vecs[8];
  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle samples of one frame followed by one idle cycle.
  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic [5:0] ps);
    int unsigned psx;
    samp_t s;
    psx = (ps == 0) ? 1 : ps;
    s = '{tx: 1'b0, busy: 1'b1};
    for (int i = 0; i < psx; i++) exp_q.push_back(s);
    for (int b = 0; b < 8; b++) begin
      s = '{tx: d[b], busy: 1'b1};
      for (int i = 0; i < psx; i++) exp_q.push_back(s);
    end
    if (pe) begin
      s = '{tx: (^d) ^ pt, busy: 1'b1};
      for (int i = 0; i < psx; i++) exp_q.push_back(s);
    end
    s = '{tx: 1'b1, busy: 1'b1};
    for (int i = 0; i < psx; i++) exp_q.push_back(s);
    s = '{tx: 1'b1, busy: 1'b0};
    exp_q.push_back(s);
  endtask

  // One clock; sample #1 after the edge and score against the queue head.
  task automatic tick(output samp_t s);
    samp_t e;
    @(posedge CLK);
    #1;
    s.tx   = TX_OUT;
    s.busy = bus.busy;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("tx_out", {31'd0, s.tx}, {31'd0, e.tx});
      check("busy", {31'd0, s.busy}, {31'd0, e.busy});
    end
  endtask

  task automatic run_frame(input vec_t v);
    samp_t       s;
    int unsigned psx, idx, busy_cnt, par_idx;
    logic        cap_par;
    psx      = (v.ps == 0) ? 1 : v.ps;
    par_idx  = 9 * psx;
    idx      = 0;
    busy_cnt = 0;
    cap_par  = 1'bx;
    bus.P_DATA     = v.data;
    bus.PAR_EN     = v.pe;
    bus.PAR_TYP    = v.pt;
    bus.Prescale   = v.ps;
    bus.Data_Valid = 1'b1;
    push_frame(v.data, v.pe, v.pt, v.ps);
    while (exp_q.size() > 0 && idx < 2000) begin
      tick(s);
      if (idx == 0) begin
        // Disturb every request input; the frame must use the latched copy.
        bus.Data_Valid = 1'b0;
        bus.P_DATA     = ~v.data;
        bus.PAR_EN     = ~v.pe;
        bus.PAR_TYP    = ~v.pt;
        bus.Prescale   = v.ps + 6'd3;
      end
      if (idx == par_idx) cap_par = s.tx;
      busy_cnt += s.busy;
      idx++;
    end
    if (exp_q.size() != 0) begin
      check("frame_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    check("busy_cycles", busy_cnt, v.exp_len);
    if (v.pe) check("parity_bit", {31'd0, cap_par}, {31'd0, v.exp_par});
  endtask

  initial begin
    samp_t s;
    vec_t  r;
    int unsigned guard;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd8,  80,  1'b0};
    vecs[1] = '{8'h03, 1'b1, 1'b0, 6'd4,  44,  1'b0};
    vecs[2] = '{8'h03, 1'b1, 1'b1, 6'd4,  44,  1'b1};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 6'd1,  10,  1'b0};
    vecs[4] = '{8'hC3, 1'b0, 1'b0, 6'd0,  10,  1'b0};
    vecs[5] = '{8'h81, 1'b0, 1'b0, 6'd63, 630, 1'b0};
    vecs[6] = '{8'h7E, 1'b1, 1'b1, 6'd3,  33,  1'b1};
    vecs[7] = '{8'h01, 1'b1, 1'b0, 6'd2,  22,  1'b1};

    bus.P_DATA     = 8'h00;
    bus.Data_Valid = 1'b1;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Prescale   = 6'd8;

    // Reset with a request pending: nothing may start.
    RST = 1'b0;
    tick(s);
    tick(s);
    check("reset_tx", {31'd0, s.tx}, 32'd1);
    check("reset_busy", {31'd0, s.busy}, 32'd0);
    bus.Data_Valid = 1'b0;
    RST = 1'b1;
    tick(s);
    check("idle_tx", {31'd0, s.tx}, 32'd1);
    check("idle_busy", {31'd0, s.busy}, 32'd0);

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // Back-to-back: Data_Valid held high, P_DATA changed mid-frame.
    bus.P_DATA     = 8'h3C;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Prescale   = 6'd2;
    bus.Data_Valid = 1'b1;
    push_frame(8'h3C, 1'b0, 1'b0, 6'd2);
    tick(s);
    bus.P_DATA = 8'h96;
    push_frame(8'h96, 1'b0, 1'b0, 6'd2);
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      tick(s);
      guard++;
    end
    bus.Data_Valid = 1'b0;
    check("b2b_len", guard, 41);
    if (exp_q.size() != 0) begin
      check("b2b_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    tick(s);
    check("b2b_idle_tx", {31'd0, s.tx}, 32'd1);
    check("b2b_idle_busy", {31'd0, s.busy}, 32'd0);

    // Reset during data bit 3 of 0xF7 (that bit is 0).
    bus.P_DATA     = 8'hF7;
    bus.PAR_EN     = 1'b0;
    bus.Prescale   = 6'd4;
    bus.Data_Valid = 1'b1;
    tick(s);
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 16; i++) tick(s);
    check("pre_rst_tx", {31'd0, s.tx}, 32'd0);
    check("pre_rst_busy", {31'd0, s.busy}, 32'd1);
    RST = 1'b0;
    tick(s);
    check("mid_rst_tx", {31'd0, s.tx}, 32'd1);
    check("mid_rst_busy", {31'd0, s.busy}, 32'd0);
    RST = 1'b1;
    tick(s);
    check("post_rst_tx", {31'd0, s.tx}, 32'd1);
    check("post_rst_busy", {31'd0, s.busy}, 32'd0);
    r = '{8'h3C, 1'b1, 1'b0, 6'd2, 22, 1'b0};
    run_frame(r);

`ifdef UART_TX_BREAK_EN
    // Break for 50 cycles with a request pending that must be ignored.
    Break = 1'b1;
    bus.P_DATA     = 8'h55;
    bus.Data_Valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(s);
      check("break_tx", {31'd0, s.tx}, 32'd0);
      check("break_busy", {31'd0, s.busy}, 32'd1);
    end
    Break = 1'b0;
    tick(s);
    bus.Data_Valid = 1'b0;
    check("break_end_tx", {31'd0, s.tx}, 32'd1);
    check("break_end_busy", {31'd0, s.busy}, 32'd0);
    tick(s);
    check("break_idle_tx", {31'd0, s.tx}, 32'd1);
    check("break_idle_busy", {31'd0, s.busy}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
